// File: rtl/audio_dac_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// audio_dac_serializer
// Buffers stereo sample pairs from the system clock domain and shifts them
// out to a codec in I2S format. The codec is bit-clock and word-clock master;
// both clocks are oversampled by clk and only their synchronized edges are
// used, so no logic runs in the codec clock domain.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   enable          playback enable; when low the data line is held at 0
//   in_valid/ready  sample pair handshake (see below)
//   in_left/right   two's complement channel words, SAMPLE_W bits each
//   aud_bclk        codec bit clock (async input)
//   aud_dac_lrck    codec word clock, 0 = left slot, 1 = right slot
//   aud_dac_dat     serial data to codec, changes after BCLK falling edges
//   underrun        one-clk pulse for each left frame that found FIFO empty
//   underrun_cnt    saturating count of underrun pulses
//
// Handshake: a pair transfers on every rising clk edge where in_valid and
// in_ready are both high. in_ready is registered and only reflects FIFO
// fullness; a pop in the same cycle does not make room for a push.
// ---------------------------------------------------------------------------
module audio_dac_serializer #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    input  logic                aud_bclk,
    input  logic                aud_dac_lrck,
    output logic                aud_dac_dat,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = $clog2(SAMPLE_W + 1);

    // Codec clock synchronizers
    logic bclk_s1_q, bclk_s2_q, bclk_h_q;
    logic lrck_s1_q, lrck_s2_q;
    // LRCK value captured at the previous BCLK falling edge
    logic lrck_prev_q, lrck_prev_d;
    logic armed_q, armed_d;

    // FIFO
    logic [SAMPLE_W-1:0] mem_l_q [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_r_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                in_ready_q, in_ready_d;

    // Serializer
    logic [SAMPLE_W-1:0] sh_q, sh_d;
    logic [CW-1:0]       bits_q, bits_d;
    logic [SAMPLE_W-1:0] held_r_q, held_r_d;
    logic                active_q, active_d;
    logic                dat_q, dat_d;
    logic                underrun_q, underrun_d;
    logic [15:0]         cnt_q, cnt_d;

    logic fall, boundary, left_start, right_start;
    logic fifo_empty, push, pop, underrun_ev;

    assign fall        = bclk_h_q & ~bclk_s2_q;
    assign boundary    = fall & armed_q & (lrck_s2_q != lrck_prev_q);
    assign left_start  = boundary & ~lrck_s2_q;
    assign right_start = boundary & lrck_s2_q;

    assign fifo_empty  = (count_q == '0);
    assign push        = in_valid & in_ready_q;
    assign pop         = left_start & enable & ~fifo_empty;
    assign underrun_ev = left_start & enable & fifo_empty;

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        in_ready_d  = (count_d != CNT_W'(FIFO_DEPTH));

        armed_d     = armed_q;
        lrck_prev_d = lrck_prev_q;
        sh_d        = sh_q;
        bits_d      = bits_q;
        held_r_d    = held_r_q;
        active_d    = active_q;
        dat_d       = dat_q;
        underrun_d  = underrun_ev;
        cnt_d       = (underrun_ev && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

        if (fall) begin
            armed_d     = 1'b1;
            lrck_prev_d = lrck_s2_q;
            // The bit driven on the boundary edge still belongs to the
            // previous word (I2S one-BCLK delay); the new word starts next edge.
            if (bits_q != '0) begin
                dat_d  = sh_q[SAMPLE_W-1];
                sh_d   = sh_q << 1;
                bits_d = bits_q - CW'(1);
            end else begin
                dat_d  = 1'b0;
            end
            if (left_start) begin
                if (enable) begin
                    active_d = 1'b1;
                    bits_d   = CW'(SAMPLE_W);
                    sh_d     = fifo_empty ? '0 : mem_l_q[rd_ptr_q];
                    held_r_d = fifo_empty ? '0 : mem_r_q[rd_ptr_q];
                end else begin
                    active_d = 1'b0;
                    bits_d   = '0;
                end
            end else if (right_start) begin
                if (active_q) begin
                    sh_d   = held_r_q;
                    bits_d = CW'(SAMPLE_W);
                end else begin
                    bits_d = '0;
                end
            end
        end

        // Disabled: silence immediately and wait for a full left frame
        if (!enable) begin
            dat_d    = 1'b0;
            bits_d   = '0;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l_q[wr_ptr_q] <= in_left;
            mem_r_q[wr_ptr_q] <= in_right;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_h_q    <= 1'b0;
            lrck_s1_q   <= 1'b0;
            lrck_s2_q   <= 1'b0;
            lrck_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            sh_q        <= '0;
            bits_q      <= '0;
            held_r_q    <= '0;
            active_q    <= 1'b0;
            dat_q       <= 1'b0;
            underrun_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            bclk_s1_q   <= aud_bclk;
            bclk_s2_q   <= bclk_s1_q;
            bclk_h_q    <= bclk_s2_q;
            lrck_s1_q   <= aud_dac_lrck;
            lrck_s2_q   <= lrck_s1_q;
            lrck_prev_q <= lrck_prev_d;
            armed_q     <= armed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            sh_q        <= sh_d;
            bits_q      <= bits_d;
            held_r_q    <= held_r_d;
            active_q    <= active_d;
            dat_q       <= dat_d;
            underrun_q  <= underrun_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign aud_dac_dat  = dat_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = cnt_q;

endmodule
